// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Shared constants for the counter family (up/down counters,
//               timers, prescalers). The mode constants select what a counter
//               does when it reaches a limit.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

    // Limit behaviour: wrap around to the opposite limit, or hold at the limit
    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/updown_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : updown_mod_counter
// Description : Parametrised modulo-(MAX+1) up/down counter with enable,
//               synchronous clear, clamped parallel load and wrap or
//               saturate behaviour at the limits.
// Ports       : clk      - clock, rising edge
//               rst      - asynchronous active-low reset
//               en       - count enable
//               up       - direction (1 = up, 0 = down)
//               clear    - synchronous clear to RESET_VAL
//               load     - synchronous parallel load of load_val
//               load_val - load value, clamped to MAX
//               count    - registered count
//               tc       - terminal count for the current direction
//               wrap     - one-cycle pulse aligned with a wrapped count
// Revision    : 1.0 - initial release
// ============================================================================
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX       = 2**WIDTH - 1,
    parameter int RESET_VAL = MAX,
    parameter int SATURATE  = CNT_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    localparam longint           c_LIMIT = (longint'(1) << WIDTH) - 1;
    localparam logic [WIDTH-1:0] c_MAX   = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] c_RESET = WIDTH'(RESET_VAL);

    // Reject parameter sets that would let the counter hold out-of-range values
    if (WIDTH < 2 || MAX < 1 || longint'(MAX) > c_LIMIT ||
        RESET_VAL < 0 || RESET_VAL > MAX ||
        (SATURATE != CNT_WRAP && SATURATE != CNT_SAT)) begin : g_param_check
        $error("updown_mod_counter: illegal parameters WIDTH=%0d MAX=%0d RESET_VAL=%0d SATURATE=%0d",
               WIDTH, MAX, RESET_VAL, SATURATE);
    end

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_wrap_nxt;

    // Next-state logic. The limit is tested before any add/subtract so the
    // arithmetic never leaves 0..MAX, even when MAX < 2**WIDTH-1.
    always_comb begin
        w_count_nxt = r_count;
        w_wrap_nxt  = 1'b0;
        if (clear) begin
            w_count_nxt = c_RESET;
        end else if (load) begin
            w_count_nxt = (load_val > c_MAX) ? c_MAX : load_val;
        end else if (en) begin
            if (up) begin
                if (r_count == c_MAX) begin
                    if (SATURATE == CNT_WRAP) begin
                        w_count_nxt = '0;
                        w_wrap_nxt  = 1'b1;
                    end
                end else begin
                    w_count_nxt = r_count + WIDTH'(1);
                end
            end else begin
                if (r_count == '0) begin
                    if (SATURATE == CNT_WRAP) begin
                        w_count_nxt = c_MAX;
                        w_wrap_nxt  = 1'b1;
                    end
                end else begin
                    w_count_nxt = r_count - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= c_RESET;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    // tc deliberately ignores en so that (tc & en) marks the limit-reaching edge
    assign tc    = up ? (r_count == c_MAX) : (r_count == '0);
    assign count = r_count;
    assign wrap  = r_wrap;

endmodule : updown_mod_counter
`default_nettype wire

// File: tb/tb_updown_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_updown_mod_counter
// Description : Directed self-checking bench for updown_mod_counter. Three
//               instances share control inputs: a 4-bit mod-10 wrapping
//               counter, a 4-bit mod-10 saturating counter and an 8-bit
//               full-range wrapping counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_mod_counter;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       en    = 1'b0;
    logic       up    = 1'b0;
    logic       clear = 1'b0;
    logic       load  = 1'b0;
    logic [3:0] load_val4 = 4'd0;
    logic [7:0] load_val8 = 8'd0;

    logic [3:0] a_count, s_count;
    logic [7:0] f_count;
    logic       a_tc, a_wrap, s_tc, s_wrap, f_tc, f_wrap;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(4), .MAX(9), .RESET_VAL(9), .SATURATE(counter_pkg::CNT_WRAP)) dut_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(load_val4), .count(a_count), .tc(a_tc), .wrap(a_wrap));

    updown_mod_counter #(.WIDTH(4), .MAX(9), .RESET_VAL(9), .SATURATE(counter_pkg::CNT_SAT)) dut_s (
        .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(load_val4), .count(s_count), .tc(s_tc), .wrap(s_wrap));

    updown_mod_counter #(.WIDTH(8), .MAX(255), .RESET_VAL(255), .SATURATE(counter_pkg::CNT_WRAP)) dut_f (
        .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(load_val8), .count(f_count), .tc(f_tc), .wrap(f_wrap));

    // One rising edge, then settle so outputs are sampled away from the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3 rst = 1'b0;          // asserted between edges
        #1;
        checks++; if (a_count !== 4'd9)   begin errors++; $display("FAIL reset_a_count got=%0d exp=9", a_count); end
        checks++; if (a_wrap  !== 1'b0)   begin errors++; $display("FAIL reset_a_wrap got=%b exp=0", a_wrap); end
        checks++; if (s_count !== 4'd9)   begin errors++; $display("FAIL reset_s_count got=%0d exp=9", s_count); end
        checks++; if (f_count !== 8'd255) begin errors++; $display("FAIL reset_f_count got=%0d exp=255", f_count); end
        #3 rst = 1'b1;          // released mid-cycle
    endtask

    task automatic test_wrap_down();
        int exp_cnt [11] = '{8, 7, 6, 5, 4, 3, 2, 1, 0, 9, 8};
        bit exp_wrap[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        en = 1'b1; up = 1'b0;
        for (int i = 0; i < 11; i++) begin
            step();
            checks++; if (a_count !== 4'(exp_cnt[i])) begin errors++; $display("FAIL down_count[%0d] got=%0d exp=%0d", i, a_count, exp_cnt[i]); end
            checks++; if (a_wrap !== exp_wrap[i]) begin errors++; $display("FAIL down_wrap[%0d] got=%b exp=%b", i, a_wrap, exp_wrap[i]); end
            checks++; if (a_tc !== (exp_cnt[i] == 0)) begin errors++; $display("FAIL down_tc[%0d] got=%b exp=%b", i, a_tc, exp_cnt[i] == 0); end
        end
        en = 1'b0;
    endtask

    task automatic test_wrap_up();
        int exp_cnt [3] = '{9, 0, 1};
        bit exp_wrap[3] = '{0, 1, 0};
        bit exp_tc  [3] = '{1, 0, 0};
        load = 1'b1; load_val4 = 4'd8;
        step();
        load = 1'b0;
        checks++; if (a_count !== 4'd8) begin errors++; $display("FAIL up_load got=%0d exp=8", a_count); end
        up = 1'b1; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (a_count !== 4'(exp_cnt[i])) begin errors++; $display("FAIL up_count[%0d] got=%0d exp=%0d", i, a_count, exp_cnt[i]); end
            checks++; if (a_wrap !== exp_wrap[i]) begin errors++; $display("FAIL up_wrap[%0d] got=%b exp=%b", i, a_wrap, exp_wrap[i]); end
            checks++; if (a_tc !== exp_tc[i]) begin errors++; $display("FAIL up_tc[%0d] got=%b exp=%b", i, a_tc, exp_tc[i]); end
        end
        en = 1'b0;
    endtask

    task automatic test_saturate();
        int exp_cnt[5] = '{8, 9, 9, 9, 9};
        bit exp_tc [5] = '{0, 1, 1, 1, 1};
        load = 1'b1; load_val4 = 4'd7;
        step();
        load = 1'b0;
        checks++; if (s_count !== 4'd7) begin errors++; $display("FAIL sat_load got=%0d exp=7", s_count); end
        up = 1'b1; en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (s_count !== 4'(exp_cnt[i])) begin errors++; $display("FAIL sat_count[%0d] got=%0d exp=%0d", i, s_count, exp_cnt[i]); end
            checks++; if (s_wrap !== 1'b0) begin errors++; $display("FAIL sat_wrap[%0d] got=%b exp=0", i, s_wrap); end
            checks++; if (s_tc !== exp_tc[i]) begin errors++; $display("FAIL sat_tc[%0d] got=%b exp=%b", i, s_tc, exp_tc[i]); end
        end
        up = 1'b0;
        step();
        en = 1'b0;
        checks++; if (s_count !== 4'd8) begin errors++; $display("FAIL sat_down_count got=%0d exp=8", s_count); end
        checks++; if (s_tc !== 1'b0)    begin errors++; $display("FAIL sat_down_tc got=%b exp=0", s_tc); end
        // Saturate at the low limit as well
        load = 1'b1; load_val4 = 4'd0;
        step();
        load = 1'b0; en = 1'b1;
        step();
        en = 1'b0;
        checks++; if (s_count !== 4'd0) begin errors++; $display("FAIL sat_low_count got=%0d exp=0", s_count); end
        checks++; if (s_wrap !== 1'b0)  begin errors++; $display("FAIL sat_low_wrap got=%b exp=0", s_wrap); end
    endtask

    task automatic test_priority_clamp();
        load = 1'b1; load_val4 = 4'd5;
        step();
        checks++; if (a_count !== 4'd5) begin errors++; $display("FAIL prio_setup got=%0d exp=5", a_count); end
        clear = 1'b1; load = 1'b1; load_val4 = 4'd3; en = 1'b1; up = 1'b1;
        step();
        clear = 1'b0;
        checks++; if (a_count !== 4'd9) begin errors++; $display("FAIL prio_clear got=%0d exp=9", a_count); end
        // load beats en
        load_val4 = 4'd3;
        step();
        checks++; if (a_count !== 4'd3) begin errors++; $display("FAIL prio_load got=%0d exp=3", a_count); end
        en = 1'b0;
        load_val4 = 4'd14;
        step();
        checks++; if (a_count !== 4'd9) begin errors++; $display("FAIL clamp_14 got=%0d exp=9", a_count); end
        load_val4 = 4'd10;
        step();
        checks++; if (a_count !== 4'd9) begin errors++; $display("FAIL clamp_10 got=%0d exp=9", a_count); end
        load_val4 = 4'd0;
        step();
        checks++; if (a_count !== 4'd0) begin errors++; $display("FAIL load_0 got=%0d exp=0", a_count); end
        checks++; if (a_wrap !== 1'b0)  begin errors++; $display("FAIL load_wrap got=%b exp=0", a_wrap); end
        load = 1'b0;
    endtask

    task automatic test_hold_async();
        load = 1'b1; load_val4 = 4'd4;
        step();
        load = 1'b0; en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (a_count !== 4'd4) begin errors++; $display("FAIL hold_count[%0d] got=%0d exp=4", i, a_count); end
            checks++; if (a_wrap !== 1'b0)  begin errors++; $display("FAIL hold_wrap[%0d] got=%b exp=0", i, a_wrap); end
        end
        load = 1'b1; load_val4 = 4'd9;
        step();
        load = 1'b0; up = 1'b1; en = 1'b1;
        step();
        en = 1'b0;
        checks++; if (a_wrap !== 1'b1)  begin errors++; $display("FAIL pre_rst_wrap got=%b exp=1", a_wrap); end
        #2 rst = 1'b0;
        #1;
        checks++; if (a_count !== 4'd9) begin errors++; $display("FAIL async_rst_count got=%0d exp=9", a_count); end
        checks++; if (a_wrap !== 1'b0)  begin errors++; $display("FAIL async_rst_wrap got=%b exp=0", a_wrap); end
        #2 rst = 1'b1;
    endtask

    // Direction flips at the limits give wrap pulses on consecutive cycles
    task automatic test_back_to_back();
        load = 1'b1; load_val4 = 4'd9;
        step();
        load = 1'b0; en = 1'b1; up = 1'b1;
        step();
        checks++; if (a_count !== 4'd0 || a_wrap !== 1'b1) begin errors++; $display("FAIL b2b_first got=%0d/%b exp=0/1", a_count, a_wrap); end
        checks++; if (a_tc !== 1'b0) begin errors++; $display("FAIL b2b_tc_up got=%b exp=0", a_tc); end
        up = 1'b0;
        #1;
        checks++; if (a_tc !== 1'b1) begin errors++; $display("FAIL b2b_tc_down got=%b exp=1", a_tc); end
        step();
        checks++; if (a_count !== 4'd9 || a_wrap !== 1'b1) begin errors++; $display("FAIL b2b_second got=%0d/%b exp=9/1", a_count, a_wrap); end
        up = 1'b1;
        step();
        en = 1'b0;
        checks++; if (a_count !== 4'd0 || a_wrap !== 1'b1) begin errors++; $display("FAIL b2b_third got=%0d/%b exp=0/1", a_count, a_wrap); end
        step();
        checks++; if (a_wrap !== 1'b0) begin errors++; $display("FAIL b2b_idle_wrap got=%b exp=0", a_wrap); end
    endtask

    task automatic test_full_range();
        int pulses = 0;
        int pulse_at = -1;
        load = 1'b1; load_val8 = 8'd0;
        step();
        load = 1'b0;
        checks++; if (f_count !== 8'd0) begin errors++; $display("FAIL full_start got=%0d exp=0", f_count); end
        up = 1'b1; en = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            step();
            if (f_wrap === 1'b1) begin
                pulses++;
                pulse_at = i;
            end
            if (i == 255) begin
                checks++; if (f_count !== 8'd255 || f_tc !== 1'b1) begin errors++; $display("FAIL full_255 got=%0d/%b exp=255/1", f_count, f_tc); end
            end
        end
        en = 1'b0;
        checks++; if (f_count !== 8'd0) begin errors++; $display("FAIL full_end got=%0d exp=0", f_count); end
        checks++; if (pulses != 1)      begin errors++; $display("FAIL full_pulses got=%0d exp=1", pulses); end
        checks++; if (pulse_at != 256)  begin errors++; $display("FAIL full_pulse_edge got=%0d exp=256", pulse_at); end
    endtask

    initial begin
        test_reset();
        test_wrap_down();
        test_wrap_up();
        test_saturate();
        test_priority_clamp();
        test_hold_async();
        test_back_to_back();
        test_full_range();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_updown_mod_counter
`default_nettype wire
